// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the 24-bit multi-cycle CPU. One shared word array
// serves two request/acknowledge ports:
//   - instruction port (read-only)
//   - data port (read/write)
// Each access takes a fixed number of wait states. When both ports request in
// the same IDLE cycle, the data port wins. The losing request is not queued.
// It is simply sampled again on the next IDLE edge.
//
// Parameters
//   DATA_W       word width in bits
//   ADDR_W       implemented address bits (array depth 2**ADDR_W words)
//   WAIT_CYCLES  wait states per access, 0..15
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   i_req    instruction read request (level, held until i_ack)
//   i_addr   instruction word address (24 bits)
//   i_rdata  instruction read data, valid while i_ack is high, held afterwards
//   i_ack    one-cycle completion pulse, instruction port
//   d_req    data request (level, held until d_ack)
//   d_we     1 = write, 0 = read
//   d_addr   data word address (24 bits)
//   d_wdata  write data
//   d_rdata  data read result, valid while d_ack is high, held afterwards
//   d_ack    one-cycle completion pulse, data port
//   err      pulses with the ack when the granted address is out of range
//   busy     high in every state except IDLE
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [23:0]       i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [23:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    // Transaction fields captured at the grant edge.
    logic [23:0]       addr_l;
    logic              we_l;
    logic [DATA_W-1:0] wdata_l;
    logic              gnt_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              access;
    logic              addr_ok;
    logic              mem_we;

    // An address is in range only when every bit above the array index is 0.
    function automatic logic in_range(input logic [23:0] a);
        return (a[23:ADDR_W] == '0);
    endfunction

    assign access  = (state == WAIT) && (cnt == 4'd0);
    assign addr_ok = in_range(addr_l);
    // rst gates the write so that a reset landing on the access edge
    // abandons the transaction without touching the array.
    assign mem_we  = !rst && access && gnt_d && we_l && addr_ok;

    // Array write port. The array has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_l[ADDR_W-1:0]] <= wdata_l;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        addr_l  <= d_addr;
                        we_l    <= d_we;
                        wdata_l <= d_wdata;
                        gnt_d   <= 1'b1;
                        cnt     <= WAIT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end else if (i_req) begin
                        addr_l  <= i_addr;
                        we_l    <= 1'b0;
                        gnt_d   <= 1'b0;
                        cnt     <= WAIT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Access edge: the array write happens in the
                        // write-port block; here we return read data and ack.
                        err   <= !addr_ok;
                        state <= DONE;
                        if (gnt_d) begin
                            d_ack <= 1'b1;
                            if (!we_l) begin
                                d_rdata <= addr_ok ? mem[addr_l[ADDR_W-1:0]] : '0;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= addr_ok ? mem[addr_l[ADDR_W-1:0]] : '0;
                        end
                    end
                end

                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder. Each driven request pushes its expected
// ack (port, data, err, ack cycle) into a queue. An independent monitor pops
// the queue and compares it whenever an ack appears.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [23:0] i_addr;
    logic [23:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [23:0] d_wdata;
    logic [23:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        busy;

    mem_responder #(
        .DATA_W(24),
        .ADDR_W(10),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_ack(i_ack),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack(d_ack),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port_d;
        logic [23:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_d_hold = 24'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every ack against the head of the scoreboard.
    always @(negedge clk) begin
        if (i_ack === 1'b1 && d_ack === 1'b1)
            check("ack_exclusive", 32'd1, 32'd0);
        if (i_ack === 1'b1 || d_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port_d});
                check("ack_cycle", cyc, mon_e.cyc);
                check("err", {31'd0, err}, {31'd0, mon_e.err});
                if (mon_e.port_d)
                    check("d_rdata", {8'd0, d_rdata}, {8'd0, mon_e.data});
                else
                    check("i_rdata", {8'd0, i_rdata}, {8'd0, mon_e.data});
            end
        end else if (err === 1'b1) begin
            check("err_without_ack", 32'd1, 32'd0);
        end
    end

    task automatic wait_d();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            // Disturb the request fields after the grant; they must be ignored.
            if (n == 1) begin
                d_addr  = 24'hFFFFFF;
                d_wdata = 24'h5A5A5A;
                d_we    = ~d_we;
            end
        end while (d_ack !== 1'b1 && n < 40);
        check("d_ack_seen", {31'd0, d_ack}, 32'd1);
    endtask

    task automatic wait_i();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (i_ack !== 1'b1 && n < 40);
        check("i_ack_seen", {31'd0, i_ack}, 32'd1);
    endtask

    task automatic push(input bit port_d, input logic [23:0] data, input bit e, input int c);
        exp_t x;
        x.port_d = port_d;
        x.data   = data;
        x.err    = e;
        x.cyc    = c;
        sb.push_back(x);
    endtask

    // One data-port access starting from IDLE. A write expects d_rdata to
    // keep the last read value.
    task automatic d_access(input bit we, input logic [23:0] addr, input logic [23:0] wd,
                            input logic [23:0] rd_exp, input bit err_exp);
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wd;
        if (!we) exp_d_hold = rd_exp;
        push(1'b1, exp_d_hold, err_exp, cyc + W + 2);
        wait_d();
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset with both requests pending: nothing may be granted.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 24'h000005;
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h000005; d_wdata = 24'h999999;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ack", {31'd0, i_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_i_rdata", {8'd0, i_rdata}, 32'd0);
        check("rst_d_rdata", {8'd0, d_rdata}, 32'd0);
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Write then read back.
        d_access(1'b1, 24'h000005, 24'hABCDEF, 24'h0, 1'b0);
        d_access(1'b0, 24'h000005, 24'h0, 24'hABCDEF, 1'b0);

        // Preload words used later.
        d_access(1'b1, 24'h000000, 24'h55AA55, 24'h0, 1'b0);
        d_access(1'b1, 24'h000001, 24'h111111, 24'h0, 1'b0);
        d_access(1'b1, 24'h000002, 24'h222222, 24'h0, 1'b0);
        d_access(1'b1, 24'h000003, 24'h333333, 24'h0, 1'b0);
        d_access(1'b1, 24'h000010, 24'h0A0B0C, 24'h0, 1'b0);

        // Simultaneous requests: data first, instruction one transaction later.
        @(negedge clk);
        c = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000010;
        i_req = 1'b1; i_addr = 24'h000005;
        exp_d_hold = 24'h0A0B0C;
        push(1'b1, 24'h0A0B0C, 1'b0, c + W + 2);
        push(1'b0, 24'hABCDEF, 1'b0, c + 2 * W + 5);
        wait_d();
        d_req = 1'b0;
        wait_i();
        i_req = 1'b0;

        // Out-of-range accesses.
        d_access(1'b1, 24'h000400, 24'h123456, 24'h0, 1'b1);
        d_access(1'b0, 24'h000000, 24'h0, 24'h55AA55, 1'b0);
        d_access(1'b0, 24'h000400, 24'h0, 24'h000000, 1'b1);
        d_access(1'b0, 24'h800005, 24'h0, 24'h000000, 1'b1);

        // Back-to-back instruction reads with i_req held high.
        @(negedge clk);
        c = cyc;
        i_req = 1'b1; i_addr = 24'h000001;
        push(1'b0, 24'h111111, 1'b0, c + W + 2);
        push(1'b0, 24'h222222, 1'b0, c + W + 2 + (W + 3));
        push(1'b0, 24'h333333, 1'b0, c + W + 2 + 2 * (W + 3));
        for (int k = 0; k < 3; k++) begin
            wait_i();
            if (k < 2) i_addr = 24'(k + 2);
            else       i_req = 1'b0;
            @(negedge clk);
            check("b2b_busy_gap", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("b2b_busy_next", {31'd0, busy}, (k < 2) ? 32'd1 : 32'd0);
        end

        // Reset on the last wait cycle of a write: no ack, no write.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h000010; d_wdata = 24'h777777;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_d_hold = 24'h0;
        check("midrst_d_ack", {31'd0, d_ack}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_d_rdata", {8'd0, d_rdata}, 32'd0);
        repeat (W + 4) @(negedge clk);
        d_access(1'b0, 24'h000010, 24'h0, 24'h0A0B0C, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
